// File: rtl/conv_1d_issue_sched.sv
// Issue sequencer for a time-multiplexed 1-D convolution.
// Walks every (position j, output channel k) pair, channel innermost, and
// issues one pair per cycle to the shared multiply core while a downstream
// buffer credit is free. A MAC_LAT-deep delay line follows each issue so the
// matching result strobe and its lines_out address (k*RESULT_W+j) come out
// exactly when the core's sum is valid. An opaque tag rides from start to done.
//
// Handshake semantics: mac_valid is a pure issue strobe (the core always
// accepts, there is no ready); an issue consumes one credit. res_ack returns
// one credit in any cycle it is high, including a cycle with res_valid; the
// credit count never exceeds CREDITS and an issue is never made without one.
module conv_1d_issue_sched #(
    parameter int IMG_W    = 32,
    parameter int FILTER_L = 3,
    parameter int RESULT_D = 8,
    parameter int STRIDE_W = 1,
    parameter int MAC_LAT  = 5,
    parameter int CREDITS  = 4,
    localparam int RESULT_W = (IMG_W - FILTER_L) / STRIDE_W + 1,
    localparam int WB_W     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    localparam int CH_W     = (RESULT_D > 1) ? $clog2(RESULT_D) : 1,
    localparam int AD_W     = (RESULT_D * RESULT_W > 1) ? $clog2(RESULT_D * RESULT_W) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      opaque_in,
    output logic            busy,
    output logic            done,
    output logic [7:0]      opaque_out,
    output logic            mac_valid,
    output logic [WB_W-1:0] win_base,
    output logic [CH_W-1:0] wgt_ch,
    output logic            res_valid,
    output logic [AD_W-1:0] res_addr,
    input  logic            res_ack,
    output logic [1:0]      state_dbg
);

    localparam int JW = (RESULT_W > 1) ? $clog2(RESULT_W) : 1;
    localparam int CW = $clog2(CREDITS + 1);

    localparam logic [JW-1:0]   J_LAST    = JW'(RESULT_W - 1);
    localparam logic [CH_W-1:0] K_LAST    = CH_W'(RESULT_D - 1);
    localparam logic [CW-1:0]   CRED_INIT = CW'(CREDITS);
    localparam logic [CW:0]     CRED_FULL = (CW + 1)'(CREDITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_nxt;

    logic [CW-1:0]   credit_q, credit_nxt;
    logic [CW:0]     cred_sum;

    // Next pair to issue (n*) and the pair currently on the outputs.
    logic [JW-1:0]   nj_q, src_j, adv_j;
    logic [CH_W-1:0] nk_q, src_k, adv_k;
    logic [WB_W-1:0] nbase_q, src_base, adv_base;
    logic [AD_W-1:0] naddr_q, src_addr, adv_addr, issue_addr_q;
    logic            last_q;
    logic            start_acc, can_issue, is_last_pair, k_wrap, pending;
    logic [7:0]      opaque_q;

    logic [MAC_LAT-1:0] dl_vld;
    logic [AD_W-1:0]    dl_addr [MAC_LAT];

    // Credits after this cycle: minus this cycle's issue, plus an ack, capped at full.
    always_comb begin
        cred_sum   = {1'b0, credit_q} + {{CW{1'b0}}, res_ack} - {{CW{1'b0}}, mac_valid};
        credit_nxt = (cred_sum > CRED_FULL) ? CRED_INIT : cred_sum[CW-1:0];
    end

    // Pick the pair to issue next cycle and its successor (address and base accumulate).
    always_comb begin
        start_acc    = (state_q == S_IDLE) && start;
        src_j        = start_acc ? '0 : nj_q;
        src_k        = start_acc ? '0 : nk_q;
        src_base     = start_acc ? '0 : nbase_q;
        src_addr     = start_acc ? '0 : naddr_q;
        is_last_pair = (src_j == J_LAST) && (src_k == K_LAST);
        k_wrap       = (src_k == K_LAST);
        adv_k        = k_wrap ? '0 : src_k + CH_W'(1);
        adv_j        = k_wrap ? src_j + JW'(1) : src_j;
        adv_base     = k_wrap ? src_base + WB_W'(STRIDE_W) : src_base;
        adv_addr     = k_wrap ? AD_W'(src_j) + AD_W'(1) : src_addr + AD_W'(RESULT_W);
        can_issue    = start_acc ||
                       ((state_q == S_RUN) && !(mac_valid && last_q) && (credit_nxt != '0));
    end

    // Results still travelling that will surface after this cycle.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < MAC_LAT - 1; i++) begin
            pending = pending | dl_vld[i];
        end
    end

    // Frame state transitions.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (mac_valid && last_q) state_nxt = S_DRAIN;
            S_DRAIN: if (!pending) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame FSM with registered issue, status and tag outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            credit_q     <= CRED_INIT;
            nj_q         <= '0;
            nk_q         <= '0;
            nbase_q      <= '0;
            naddr_q      <= '0;
            issue_addr_q <= '0;
            last_q       <= 1'b0;
            opaque_q     <= '0;
            opaque_out   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mac_valid    <= 1'b0;
            win_base     <= '0;
            wgt_ch       <= '0;
        end else begin
            state_q  <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_DONE);
            credit_q <= start_acc ? CRED_INIT : credit_nxt;
            if (start_acc) begin
                opaque_q <= opaque_in;
            end
            if (state_nxt == S_DONE) begin
                opaque_out <= opaque_q;
            end
            if (can_issue) begin
                mac_valid    <= 1'b1;
                win_base     <= src_base;
                wgt_ch       <= src_k;
                issue_addr_q <= src_addr;
                last_q       <= is_last_pair;
                nj_q         <= adv_j;
                nk_q         <= adv_k;
                nbase_q      <= adv_base;
                naddr_q      <= adv_addr;
            end else begin
                mac_valid <= 1'b0;
            end
        end
    end

    // Fixed-latency shadow of the multiply core: no stall, no reordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_vld <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                dl_addr[i] <= '0;
            end
        end else begin
            dl_vld[0]  <= mac_valid;
            dl_addr[0] <= issue_addr_q;
            for (int i = 1; i < MAC_LAT; i++) begin
                dl_vld[i]  <= dl_vld[i-1];
                dl_addr[i] <= dl_addr[i-1];
            end
        end
    end

    assign res_valid = dl_vld[MAC_LAT-1];
    assign res_addr  = dl_addr[MAC_LAT-1];
    assign state_dbg = state_q;

endmodule
